// File: rtl/dlsc_mt9v032_pkg.sv
// Shared constants, state encoding and frame helpers for the MT9V032 lane aligner.
package dlsc_mt9v032_pkg;

  localparam int         FRAME_BITS = 12;
  localparam int         DATA_BITS  = 10;
  localparam int         SR_BITS    = 24;
  localparam logic       START_BIT  = 1'b1;
  localparam logic       STOP_BIT   = 1'b0;
  localparam logic [9:0] SYNC_CODE  = 10'h3FF;
  localparam logic [3:0] OFFSET_MAX = 4'd11;

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Offsets wrap 11 -> 0 so every bit position of the 12-bit frame is tried.
  function automatic logic [3:0] next_offset(input logic [3:0] off);
    logic [3:0] nxt;
    if (off == OFFSET_MAX) begin
      nxt = 4'd0;
    end else begin
      nxt = off + 4'd1;
    end
    return nxt;
  endfunction

  function automatic logic frame_good(input logic [FRAME_BITS-1:0] win);
    return (win[0] == START_BIT) && (win[FRAME_BITS-1] == STOP_BIT);
  endfunction

endpackage

// File: rtl/dlsc_mt9v032_bitwindow.sv
// 24-bit ISERDES history and offset-selected 12-bit frame window.
module dlsc_mt9v032_bitwindow
  import dlsc_mt9v032_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            in_data,
  input  logic [3:0]            offset,
  output logic [FRAME_BITS-1:0] win
);

  logic [SR_BITS-1:0] r_sr;

  // Newest word enters at the top, so r_sr[0] is always the oldest serial bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= {SR_BITS{1'b0}};
    end else begin
      r_sr <= {in_data, r_sr[SR_BITS-1:6]};
    end
  end

  // Window mux: win[0] is the candidate start bit at r_sr[offset].
  always_comb begin
    win = r_sr[11:0];
    case (offset)
      4'd0:    win = r_sr[11:0];
      4'd1:    win = r_sr[12:1];
      4'd2:    win = r_sr[13:2];
      4'd3:    win = r_sr[14:3];
      4'd4:    win = r_sr[15:4];
      4'd5:    win = r_sr[16:5];
      4'd6:    win = r_sr[17:6];
      4'd7:    win = r_sr[18:7];
      4'd8:    win = r_sr[19:8];
      4'd9:    win = r_sr[20:9];
      4'd10:   win = r_sr[21:10];
      4'd11:   win = r_sr[22:11];
      default: win = r_sr[11:0];
    endcase
  end

endmodule

// File: rtl/dlsc_mt9v032_aligner.sv
// MT9V032 LVDS lane aligner: searches the 12 bit offsets for start/stop framing,
// locks after repeated good frames and emits registered 10-bit pixels.
module dlsc_mt9v032_aligner
  import dlsc_mt9v032_pkg::*;
#(
  parameter int LOCK_CHECKS = 16,
  parameter int ERR_LIMIT   = 4,
  parameter int ERR_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [5:0]          in_data,
  input  logic                align_restart,
  output logic                out_valid,
  output logic [9:0]          out_data,
  output logic                out_sync,
  output logic                locked,
  output logic [3:0]          offset,
  output logic [ERR_BITS-1:0] err_count
);

  localparam logic [7:0]          LOCK_LAST = 8'(LOCK_CHECKS - 1);
  localparam logic [3:0]          ERR_LAST  = 4'(ERR_LIMIT - 1);
  localparam logic [ERR_BITS-1:0] ERR_MAX   = {ERR_BITS{1'b1}};
  localparam logic [ERR_BITS-1:0] ERR_ONE   = ERR_BITS'(1'b1);

  state_t                r_state;
  logic                  r_prime_cnt;
  logic [7:0]            r_good_cnt;
  logic [3:0]            r_bad_cnt;
  logic [3:0]            r_offset;
  logic                  r_locked;
  logic [ERR_BITS-1:0]   r_err_count;
  logic                  r_out_valid;
  logic [DATA_BITS-1:0]  r_out_data;
  logic                  r_out_sync;

  logic [FRAME_BITS-1:0] w_win;
  logic                  w_good;
  logic [DATA_BITS-1:0]  w_pixel;
  logic [3:0]            w_offset_next;

  dlsc_mt9v032_bitwindow u_bitwindow (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .offset  (r_offset),
    .win     (w_win)
  );

  // Frame classification and next search offset for the current window.
  always_comb begin
    w_good        = frame_good(w_win);
    w_pixel       = w_win[DATA_BITS:1];
    w_offset_next = next_offset(r_offset);
  end

  // Alignment FSM with registered pixel stream and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PRIME;
      r_prime_cnt <= 1'b0;
      r_good_cnt  <= 8'd0;
      r_bad_cnt   <= 4'd0;
      r_offset    <= 4'd0;
      r_locked    <= 1'b0;
      r_err_count <= {ERR_BITS{1'b0}};
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_BITS{1'b0}};
      r_out_sync  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_sync  <= 1'b0;
      if (align_restart) begin
        // Restart wins over the eval action; err_count deliberately survives.
        r_state     <= ST_PRIME;
        r_prime_cnt <= 1'b0;
        r_good_cnt  <= 8'd0;
        r_bad_cnt   <= 4'd0;
        r_offset    <= 4'd0;
        r_locked    <= 1'b0;
      end else if (clk_en) begin
        case (r_state)
          ST_PRIME: begin
            if (r_prime_cnt) begin
              r_state     <= ST_SEARCH;
              r_prime_cnt <= 1'b0;
              r_good_cnt  <= 8'd0;
            end else begin
              r_prime_cnt <= 1'b1;
            end
          end
          ST_SEARCH: begin
            if (w_good) begin
              if (r_good_cnt == LOCK_LAST) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_good_cnt <= 8'd0;
                r_bad_cnt  <= 4'd0;
              end else begin
                r_good_cnt <= r_good_cnt + 8'd1;
              end
            end else begin
              r_good_cnt <= 8'd0;
              r_offset   <= w_offset_next;
            end
          end
          ST_LOCKED: begin
            if (w_good) begin
              r_bad_cnt   <= 4'd0;
              r_out_valid <= 1'b1;
              r_out_data  <= w_pixel;
              r_out_sync  <= (w_pixel == SYNC_CODE);
            end else begin
              if (r_err_count != ERR_MAX) begin
                r_err_count <= r_err_count + ERR_ONE;
              end
              if (r_bad_cnt == ERR_LAST) begin
                r_state    <= ST_SEARCH;
                r_locked   <= 1'b0;
                r_good_cnt <= 8'd0;
                r_bad_cnt  <= 4'd0;
                r_offset   <= w_offset_next;
              end else begin
                r_bad_cnt <= r_bad_cnt + 4'd1;
              end
            end
          end
          default: begin
            r_state     <= ST_PRIME;
            r_prime_cnt <= 1'b0;
            r_good_cnt  <= 8'd0;
            r_bad_cnt   <= 4'd0;
            r_offset    <= 4'd0;
            r_locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sync  = r_out_sync;
  assign locked    = r_locked;
  assign offset    = r_offset;
  assign err_count = r_err_count;

endmodule
